hdlc_tx_framer: RTL and testbench

Serial HDLC transmit framer, the transmit counterpart of the HDLC receive path. It pulls frame bytes from the Tx buffer and serialises them onto Tx, one bit per Clk. Each frame is sent as: opening flag, LSB-first data with zero insertion, 16-bit FCS, closing flag. It also generates the abort sequence and the all-ones idle pattern, and reports Tx_ValidFrame, Tx_AbortedTrans and Tx_Done to the control/status logic.

---
 rtl/hdlc_pkg.sv | 22 ++
 rtl/hdlc_tx_framer_if.sv | 24 ++
 rtl/hdlc_crc16.sv | 27 ++
 rtl/hdlc_tx_framer.sv | 206 ++++++++++++++++++++
 tb/tb_hdlc_tx_framer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hdlc_pkg.sv
// Shared HDLC definitions: framer state encoding, flag/abort/stuffing constants, FCS polynomial.
package hdlc_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CRC_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    FLAG_OPEN,
    DATA,
    FCS,
    FLAG_CLOSE,
    ABORT
  } tx_state_t;

  localparam logic [BYTE_W-1:0] FLAG_PATTERN    = 8'h7E;
  localparam int unsigned       ABORT_ONES      = 7;
  localparam int unsigned       STUFF_LIMIT     = 5;
  localparam logic [CRC_W-1:0]  CRC16_POLY_REFL = 16'h8408;
  localparam logic [CRC_W-1:0]  CRC16_XOROUT    = 16'hFFFF;

endpackage

// File: rtl/hdlc_tx_framer_if.sv
// Tx buffer / control-status bundle between the framer (slave) and its environment (master).
interface hdlc_tx_framer_if;
  import hdlc_pkg::*;

  logic              Tx_Enable;
  logic [BYTE_W-1:0] Tx_FrameSize;
  logic              Tx_AbortFrame;
  logic [BYTE_W-1:0] Tx_DataOutBuff;
  logic              Tx_RdBuff;
  logic              Tx;
  logic              Tx_ValidFrame;
  logic              Tx_AbortedTrans;
  logic              Tx_Done;

  modport master (
    output Tx_Enable, Tx_FrameSize, Tx_AbortFrame, Tx_DataOutBuff,
    input  Tx_RdBuff, Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done
  );

  modport slave (
    input  Tx_Enable, Tx_FrameSize, Tx_AbortFrame, Tx_DataOutBuff,
    output Tx_RdBuff, Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done
  );
endinterface

// File: rtl/hdlc_crc16.sv
// Serial reflected CRC-16 (one bit per enabled cycle); shared by the Tx framer and Rx FCS checker.
module hdlc_crc16
  import hdlc_pkg::*;
#(
  parameter logic [CRC_W-1:0] INIT = 16'hFFFF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             i_init,
  input  logic             i_enable,
  input  logic             i_bit,
  output logic [CRC_W-1:0] o_crc
);

  logic [CRC_W-1:0] r_crc;
  logic             w_fb;

  assign w_fb  = r_crc[0] ^ i_bit;
  assign o_crc = r_crc;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)           r_crc <= '0;
    else if (i_init)   r_crc <= INIT;
    else if (i_enable) r_crc <= (r_crc >> 1) ^ (w_fb ? CRC16_POLY_REFL : '0);
  end

endmodule

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: flag, zero-stuffed LSB-first payload, complemented CRC-16 FCS, flag.
// Also emits the abort sequence; idles the line at all-ones.
module hdlc_tx_framer
  import hdlc_pkg::*;
#(
  parameter int unsigned      MAX_FRAME_BYTES = 126,
  parameter logic [CRC_W-1:0] CRC_INIT        = 16'hFFFF
) (
  input logic              Clk,
  input logic              Rst,
  hdlc_tx_framer_if.slave  bus
);

  localparam logic [BYTE_W-1:0] MAX_SIZE  = BYTE_W'(MAX_FRAME_BYTES);
  localparam logic [2:0]        STUFF_CNT = 3'(STUFF_LIMIT);
  localparam logic [3:0]        ABORT_END = 4'(ABORT_ONES);

  tx_state_t         r_state, w_state;
  logic [3:0]        r_idx, w_idx;
  logic [2:0]        r_ones, w_ones;
  logic [BYTE_W-1:0] r_byte_cnt, w_byte_cnt;
  logic [BYTE_W-1:0] r_size, w_size;
  logic [BYTE_W-1:0] r_shift, w_shift;
  logic [BYTE_W-1:0] r_buf;
  logic              r_rd_q;
  logic              r_tx, w_tx;
  logic              r_valid, w_valid;
  logic              r_rd, w_rd;
  logic              r_abt, w_abt;
  logic              r_done, w_done;
  logic              w_crc_init, w_crc_en;
  logic              w_start, w_abort_req, w_stuff;
  logic [CRC_W-1:0]  w_crc, w_fcs;

  hdlc_crc16 #(.INIT(CRC_INIT)) u_crc (
    .Clk      (Clk),
    .Rst      (Rst),
    .i_init   (w_crc_init),
    .i_enable (w_crc_en),
    .i_bit    (w_tx),
    .o_crc    (w_crc)
  );

  assign w_fcs       = w_crc ^ CRC16_XOROUT;
  assign w_start     = bus.Tx_Enable && (bus.Tx_FrameSize != '0) && (bus.Tx_FrameSize <= MAX_SIZE);
  assign w_abort_req = bus.Tx_AbortFrame &&
                       ((r_state == FLAG_OPEN) || (r_state == DATA) || (r_state == FCS));
  assign w_stuff     = (r_ones == STUFF_CNT);

  // Registers describe the bit currently on the line; next-state logic picks the following bit.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_ones     <= '0;
      r_byte_cnt <= '0;
      r_size     <= '0;
      r_shift    <= '0;
      r_buf      <= '0;
      r_rd_q     <= 1'b0;
      r_tx       <= 1'b1;
      r_valid    <= 1'b0;
      r_rd       <= 1'b0;
      r_abt      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_idx      <= w_idx;
      r_ones     <= w_ones;
      r_byte_cnt <= w_byte_cnt;
      r_size     <= w_size;
      r_shift    <= w_shift;
      r_rd_q     <= r_rd;
      if (r_rd_q) r_buf <= bus.Tx_DataOutBuff;
      r_tx       <= w_tx;
      r_valid    <= w_valid;
      r_rd       <= w_rd;
      r_abt      <= w_abt;
      r_done     <= w_done;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_idx      = r_idx;
    w_ones     = r_ones;
    w_byte_cnt = r_byte_cnt;
    w_size     = r_size;
    w_shift    = r_shift;
    w_tx       = 1'b1;
    w_valid    = r_valid;
    w_rd       = 1'b0;
    w_abt      = r_abt;
    w_done     = 1'b0;
    w_crc_init = 1'b0;
    w_crc_en   = 1'b0;

    case (r_state)
      IDLE: begin
        w_valid = 1'b0;
        if (w_start) begin
          w_state    = FLAG_OPEN;
          w_idx      = '0;
          w_tx       = FLAG_PATTERN[0];
          w_valid    = 1'b1;
          w_rd       = 1'b1;
          w_abt      = 1'b0;
          w_size     = bus.Tx_FrameSize;
          w_byte_cnt = '0;
          w_crc_init = 1'b1;
        end
      end
      FLAG_OPEN: begin
        if (r_idx == 4'd7) begin
          w_state  = DATA;
          w_idx    = '0;
          w_shift  = r_buf;
          w_tx     = r_buf[0];
          w_crc_en = 1'b1;
          w_ones   = 3'(r_buf[0]);
          w_rd     = (r_size > 8'd1);
        end else begin
          w_idx = 4'(r_idx + 4'd1);
          w_tx  = FLAG_PATTERN[3'(r_idx + 4'd1)];
        end
      end
      DATA: begin
        if (w_stuff) begin
          w_tx   = 1'b0;
          w_ones = '0;
        end else begin
          if (r_idx < 4'd7) begin
            w_idx    = 4'(r_idx + 4'd1);
            w_tx     = r_shift[3'(r_idx + 4'd1)];
            w_crc_en = 1'b1;
          end else if (8'(r_byte_cnt + 8'd1) == r_size) begin
            w_state = FCS;
            w_idx   = '0;
            w_tx    = w_fcs[0];
          end else begin
            w_byte_cnt = 8'(r_byte_cnt + 8'd1);
            w_idx      = '0;
            w_shift    = r_buf;
            w_tx       = r_buf[0];
            w_crc_en   = 1'b1;
            w_rd       = (8'(r_byte_cnt + 8'd2) < r_size);
          end
          w_ones = w_tx ? 3'(r_ones + 3'd1) : '0;
        end
      end
      FCS: begin
        if (w_stuff) begin
          w_tx   = 1'b0;
          w_ones = '0;
        end else if (r_idx < 4'd15) begin
          w_idx  = 4'(r_idx + 4'd1);
          w_tx   = w_fcs[4'(r_idx + 4'd1)];
          w_ones = w_tx ? 3'(r_ones + 3'd1) : '0;
        end else begin
          w_state = FLAG_CLOSE;
          w_idx   = '0;
          w_tx    = FLAG_PATTERN[0];
          w_valid = 1'b0;
        end
      end
      FLAG_CLOSE: begin
        if (r_idx == 4'd7) begin
          w_state = IDLE;
          w_idx   = '0;
          w_done  = 1'b1;
        end else begin
          w_idx = 4'(r_idx + 4'd1);
          w_tx  = FLAG_PATTERN[3'(r_idx + 4'd1)];
        end
      end
      ABORT: begin
        if (r_idx == '0) w_abt = 1'b1;
        if (r_idx == ABORT_END) begin
          w_state = IDLE;
          w_idx   = '0;
        end else begin
          w_idx = 4'(r_idx + 4'd1);
        end
      end
      default: w_state = IDLE;
    endcase

    // Abort overrides whatever the frame would have sent next.
    if (w_abort_req) begin
      w_state  = ABORT;
      w_idx    = '0;
      w_tx     = 1'b0;
      w_valid  = 1'b0;
      w_rd     = 1'b0;
      w_crc_en = 1'b0;
      w_ones   = '0;
    end
  end

  assign bus.Tx              = r_tx;
  assign bus.Tx_ValidFrame   = r_valid;
  assign bus.Tx_RdBuff       = r_rd;
  assign bus.Tx_AbortedTrans = r_abt;
  assign bus.Tx_Done         = r_done;

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed scoreboard bench for hdlc_tx_framer: per-cycle expected line/status pushed per frame, popped at negedge.
module tb_hdlc_tx_framer;
  import hdlc_pkg::*;

  typedef struct packed {
    logic tx;
    logic valid;
    logic abt;
    logic done;
  } exp_t;
  typedef logic [7:0] byte_q_t[$];

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  hdlc_tx_framer_if bus ();

  hdlc_tx_framer #(.MAX_FRAME_BYTES(126), .CRC_INIT(16'hFFFF)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  exp_t       exp_q[$];
  logic [7:0] buf_q[$];
  logic       cap_q[$];
  byte_q_t    d;
  int         n_vec = 0;
  int         n_err = 0;
  int         rd_count = 0;
  int         base;
  logic [31:0] rx;
  logic [18:0] ff_line;
  logic [15:0] fcs_ff;

  // Tx buffer model: byte appears the cycle after each read strobe.
  initial begin
    bus.Tx_DataOutBuff = 8'h00;
    forever begin
      @(negedge Clk);
      if (bus.Tx_RdBuff === 1'b1) begin
        rd_count++;
        if (buf_q.size() > 0) bus.Tx_DataOutBuff = buf_q.pop_front();
        else                  bus.Tx_DataOutBuff = 8'h00;
      end
    end
  end

  function automatic exp_t mk(input logic t, input logic v, input logic a, input logic dn);
    return exp_t'({t, v, a, dn});
  endfunction

  function automatic logic [15:0] tb_fcs(input byte_q_t b);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (b[i]) begin
      for (int j = 0; j < 8; j++) begin
        if (c[0] ^ b[i][j]) c = (c >> 1) ^ 16'h8408;
        else                c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b (tx,valid,abt,done)", tag, obs, expv);
    end
  endtask

  task automatic cmp_int(input string tag, input int obs, input int expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_idle(input int n, input logic abt);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(1'b1, 1'b0, abt, 1'b0));
  endtask

  // Full expected frame: flag, stuffed payload+FCS, closing flag, Done pulse, idle.
  task automatic push_frame(input byte_q_t b, input logic [15:0] fcs);
    logic ub[$];
    int   ones;
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(FLAG_PATTERN[i], 1'b1, 1'b0, 1'b0));
    foreach (b[i]) begin
      buf_q.push_back(b[i]);
      for (int j = 0; j < 8; j++) ub.push_back(b[i][j]);
    end
    for (int j = 0; j < 16; j++) ub.push_back(fcs[j]);
    ones = 0;
    foreach (ub[i]) begin
      exp_q.push_back(mk(ub[i], 1'b1, 1'b0, 1'b0));
      ones = ub[i] ? ones + 1 : 0;
      if (ones == 5) begin
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
        ones = 0;
      end
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(FLAG_PATTERN[i], 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic start(input logic [7:0] size);
    bus.Tx_Enable    = 1'b1;
    bus.Tx_FrameSize = size;
  endtask

  task automatic run(input string tag, input int abort_at, input int en_at, input int stop_at);
    int   k;
    exp_t e;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge Clk);
      bus.Tx_Enable     = 1'b0;
      bus.Tx_AbortFrame = 1'b0;
      e = exp_q.pop_front();
      cap_q.push_back(bus.Tx);
      cmp($sformatf("%s[%0d]", tag, k),
          {bus.Tx, bus.Tx_ValidFrame, bus.Tx_AbortedTrans, bus.Tx_Done}, e);
      if (k == abort_at) bus.Tx_AbortFrame = 1'b1;
      if (k == en_at) begin
        bus.Tx_Enable    = 1'b1;
        bus.Tx_FrameSize = 8'd5;
      end
      k++;
      if (k == stop_at) exp_q.delete();
    end
  endtask

  initial begin
    int nb;
    int ones;
    bus.Tx_Enable     = 1'b0;
    bus.Tx_FrameSize  = 8'd0;
    bus.Tx_AbortFrame = 1'b0;
    Rst = 1'b1;

    @(negedge Clk);
    cmp("reset", {bus.Tx, bus.Tx_ValidFrame, bus.Tx_AbortedTrans, bus.Tx_Done}, 4'b1000);
    cmp_int("reset_rd", int'(bus.Tx_RdBuff), 0);
    Rst = 1'b0;

    push_idle(20, 1'b0);
    run("idle", -1, -1, -1);
    cmp_int("idle_rd", rd_count, 0);

    // "123456789" with known X-25 FCS; stray Tx_Enable mid-frame must be ignored
    d.delete();
    for (int i = 0; i < 9; i++) d.push_back(8'(8'h31 + i));
    base = rd_count;
    push_frame(d, 16'h906E);
    start(8'd9);
    run("crc9", -1, 20, -1);
    cmp_int("crc9_rd", rd_count - base, 9);

    // all-ones payload exercises zero insertion
    d.delete();
    d.push_back(8'hFF);
    d.push_back(8'hFF);
    fcs_ff = tb_fcs(d);
    base = rd_count;
    cap_q.delete();
    push_frame(d, fcs_ff);
    start(8'd2);
    run("ones", -1, -1, -1);
    cmp_int("ones_rd", rd_count - base, 2);
    ff_line = '0;
    for (int i = 0; i < 19; i++) ff_line[i] = cap_q[8 + i];
    cmp_int("ones_line", int'(ff_line), int'(19'b1011111011111011111));
    rx = '0;
    nb = 0;
    ones = 0;
    for (int i = 8; i < cap_q.size() && nb < 32; i++) begin
      if (ones == 5) begin
        ones = 0;
      end else begin
        rx[nb] = cap_q[i];
        nb++;
        ones = cap_q[i] ? ones + 1 : 0;
      end
    end
    cmp_int("ones_rx_b0", int'(rx[7:0]), 8'hFF);
    cmp_int("ones_rx_b1", int'(rx[15:8]), 8'hFF);
    cmp_int("ones_rx_fcs", int'(rx[31:16]), int'(fcs_ff));

    // abort on the third data bit of a 4-byte frame
    buf_q.push_back(8'hA5);
    buf_q.push_back(8'h3C);
    buf_q.push_back(8'h5A);
    buf_q.push_back(8'hC3);
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(FLAG_PATTERN[i], 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 7; i++) exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0));
    push_idle(4, 1'b1);
    base = rd_count;
    start(8'd4);
    run("abort", 10, -1, -1);
    cmp_int("abort_rd", rd_count - base, 2);
    buf_q.delete();

    // single zero byte after abort: sticky status clears with the first flag bit
    d.delete();
    d.push_back(8'h00);
    base = rd_count;
    push_frame(d, tb_fcs(d));
    start(8'd1);
    run("one_byte", -1, -1, -1);
    cmp_int("one_byte_rd", rd_count - base, 1);

    // illegal sizes are ignored
    base = rd_count;
    push_idle(12, 1'b0);
    start(8'd0);
    run("size0", -1, -1, -1);
    push_idle(12, 1'b0);
    start(8'd127);
    run("size127", -1, -1, -1);
    cmp_int("bad_size_rd", rd_count - base, 0);

    // asynchronous reset in the middle of DATA
    d.delete();
    d.push_back(8'h12);
    d.push_back(8'h34);
    d.push_back(8'h56);
    d.push_back(8'h78);
    push_frame(d, tb_fcs(d));
    start(8'd4);
    run("pre_rst", -1, -1, 14);
    #1 Rst = 1'b1;
    #1;
    cmp("async_rst", {bus.Tx, bus.Tx_ValidFrame, bus.Tx_AbortedTrans, bus.Tx_Done}, 4'b1000);
    cmp_int("async_rst_rd", int'(bus.Tx_RdBuff), 0);
    @(negedge Clk);
    Rst = 1'b0;
    buf_q.delete();
    base = rd_count;
    push_idle(10, 1'b0);
    run("post_rst", -1, -1, -1);
    cmp_int("post_rst_rd", rd_count - base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
